// File: rtl/dht_poll_scheduler.sv
// dht_poll_scheduler: periodically triggers a DHT reader transaction and
// validates the returned frame. It retries failed reads and commits good
// frames to the I2C-facing register only while the I2C slave is idle.
//
// Ports:
//   CLCK        system clock (rising edge)
//   RST         synchronous active-high reset
//   enable      polling enable; only honoured in IDLE and GAP
//   i2c_busy    I2C slave transaction in progress (synchronous)
//   dht_start   one-cycle pulse that launches a reader transaction
//   dht_done    one-cycle pulse: reader transaction finished
//   dht_err     reader protocol error (valid with dht_done)
//   dht_data    raw frame {hum_int, hum_dec, tmp_int, tmp_dec, checksum}
//   regdata     last committed good frame
//   data_valid  a good frame has been committed since reset
//   fault       the most recent poll failed after all retries
//   err_count   saturating count of failed polls
module dht_poll_scheduler #(
    parameter int unsigned POLL_PERIOD = 100000000,
    parameter int unsigned RETRY_GAP   = 5000000,
    parameter int unsigned TIMEOUT     = 2000000,
    parameter int unsigned RETRY_MAX   = 2
) (
    input  logic        CLCK,
    input  logic        RST,
    input  logic        enable,
    input  logic        i2c_busy,
    output logic        dht_start,
    input  logic        dht_done,
    input  logic        dht_err,
    input  logic [39:0] dht_data,
    output logic [39:0] regdata,
    output logic        data_valid,
    output logic        fault,
    output logic [7:0]  err_count
);

    localparam int unsigned GAP_MAX = (POLL_PERIOD > RETRY_GAP) ? POLL_PERIOD : RETRY_GAP;
    localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RT_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] POLL_LOAD  = GAP_W'(POLL_PERIOD);
    localparam logic [GAP_W-1:0] RETRY_LOAD = GAP_W'(RETRY_GAP);
    localparam logic [RT_W-1:0]  RETRY_LIM  = RT_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        WAIT_DONE   = 3'd2,
        CHECK       = 3'd3,
        COMMIT_WAIT = 3'd4,
        GAP         = 3'd5
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   tcnt;
    logic [GAP_W-1:0]  gcnt;
    logic [RT_W-1:0]   retry;
    logic [39:0]       shadow_data;
    logic              shadow_err;

    logic [7:0]        sum_c;
    logic              frame_good_c;
    logic              fail_c;
    logic              commit_c;

    // Frame validation and the two shared outcomes (commit / failure).
    always_comb begin
        sum_c        = shadow_data[39:32] + shadow_data[31:24]
                     + shadow_data[23:16] + shadow_data[15:8];
        frame_good_c = !shadow_err && (sum_c == shadow_data[7:0]);
        // dht_done in the final timeout cycle takes precedence over the timeout.
        fail_c       = ((state == WAIT_DONE) && !dht_done && (tcnt == TO_LAST))
                     || ((state == CHECK) && !frame_good_c);
        commit_c     = !i2c_busy &&
                       (((state == CHECK) && frame_good_c) || (state == COMMIT_WAIT));
    end

    // Sequencer; commit and failure handling follow the case so they override it.
    always_ff @(posedge CLCK) begin
        if (RST) begin
            state       <= IDLE;
            dht_start   <= 1'b0;
            regdata     <= 40'h0;
            data_valid  <= 1'b0;
            fault       <= 1'b0;
            err_count   <= 8'h00;
            tcnt        <= '0;
            gcnt        <= '0;
            retry       <= '0;
            shadow_data <= 40'h0;
            shadow_err  <= 1'b0;
        end else begin
            dht_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= START;
                        dht_start <= 1'b1;
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (dht_done) begin
                        shadow_data <= dht_data;
                        shadow_err  <= dht_err;
                        state       <= CHECK;
                    end else if (tcnt != TO_LAST) begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    if (frame_good_c && i2c_busy) begin
                        state <= COMMIT_WAIT;
                    end
                end
                COMMIT_WAIT: begin
                    state <= COMMIT_WAIT;
                end
                GAP: begin
                    if (gcnt != '0) begin
                        gcnt <= gcnt - GAP_W'(1);
                    end
                    // Leave after the counter has been decremented to zero.
                    if (gcnt <= GAP_W'(1)) begin
                        if (enable) begin
                            state     <= START;
                            dht_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (commit_c) begin
                regdata    <= shadow_data;
                data_valid <= 1'b1;
                fault      <= 1'b0;
                retry      <= '0;
                gcnt       <= POLL_LOAD;
                state      <= GAP;
            end

            if (fail_c) begin
                if (retry < RETRY_LIM) begin
                    retry <= retry + RT_W'(1);
                    gcnt  <= RETRY_LOAD;
                end else begin
                    fault <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    retry <= '0;
                    gcnt  <= POLL_LOAD;
                end
                state <= GAP;
            end
        end
    end

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// tb_dht_poll_scheduler: directed and randomized checks of dht_poll_scheduler
// against a transaction-level model of the poll/retry/commit rules.
module tb_dht_poll_scheduler;

    localparam int unsigned POLL = 100;
    localparam int unsigned GAPR = 20;
    localparam int unsigned TMO  = 50;
    localparam int unsigned RMAX = 2;

    logic        CLCK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        dht_start;
    logic        dht_done = 1'b0;
    logic        dht_err = 1'b0;
    logic [39:0] dht_data = 40'h0;
    logic [39:0] regdata;
    logic        data_valid;
    logic        fault;
    logic [7:0]  err_count;

    dht_poll_scheduler #(
        .POLL_PERIOD (POLL),
        .RETRY_GAP   (GAPR),
        .TIMEOUT     (TMO),
        .RETRY_MAX   (RMAX)
    ) dut (
        .CLCK       (CLCK),
        .RST        (RST),
        .enable     (enable),
        .i2c_busy   (i2c_busy),
        .dht_start  (dht_start),
        .dht_done   (dht_done),
        .dht_err    (dht_err),
        .dht_data   (dht_data),
        .regdata    (regdata),
        .data_valid (data_valid),
        .fault      (fault),
        .err_count  (err_count)
    );

    always #5 CLCK = ~CLCK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    logic [39:0] m_reg = 40'h0;
    bit          m_valid = 1'b0;
    bit          m_fault = 1'b0;
    int          m_err = 0;
    int          m_retry = 0;
    int          exp_next = -1;

    task automatic tick();
        @(posedge CLCK);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit good_frame(input logic [39:0] f, input bit e);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return !e && ((s % 256) == int'(f[7:0]));
    endfunction

    function automatic logic [39:0] mk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        int s;
        s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        return {a, b, c, d, 8'(s)};
    endfunction

    function automatic logic [39:0] rnd_good();
        return mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    // Poll outcome per the retry rules; returns the idle gap that follows.
    task automatic model_outcome(input bit good, input logic [39:0] f, output int gap);
        if (good) begin
            m_reg = f; m_valid = 1'b1; m_fault = 1'b0; m_retry = 0; gap = POLL;
        end else if (m_retry < RMAX) begin
            m_retry++; gap = GAPR;
        end else begin
            m_fault = 1'b1; m_err = (m_err < 255) ? m_err + 1 : 255; m_retry = 0; gap = POLL;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_regdata"}, regdata, m_reg);
        check({tag, "_valid"}, data_valid, m_valid);
        check({tag, "_fault"}, fault, m_fault);
        check({tag, "_errcnt"}, err_count, 64'(m_err));
    endtask

    task automatic wait_start(output int s);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (dht_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("start_seen", found, 1);
        s = cyc;
        if (exp_next >= 0) check("start_time", s, exp_next);
        tick();
        check("start_width", dht_start, 0);
    endtask

    // One reader transaction: delay=0 means no dht_done (timeout).
    task automatic attempt(input string tag, input logic [39:0] f, input bit e,
                           input int delay, input int busy_hold, input bit stray);
        int s, d, gap;
        bit good;
        wait_start(s);
        if (delay > 0) begin
            while (cyc < s + delay) tick();
            dht_data = f; dht_err = e; dht_done = 1'b1;
            if (busy_hold > 0) i2c_busy = 1'b1;
            tick();
            dht_done = 1'b0;
            dht_data = {$urandom, 8'($urandom)};
            dht_err  = 1'($urandom);
            good = good_frame(f, e);
            if (good && busy_hold > 0) begin
                for (int k = 0; k < busy_hold; k++) begin
                    check({tag, "_hold_busy"}, regdata, m_reg);
                    tick();
                end
                check({tag, "_hold_busy_last"}, regdata, m_reg);
            end
            i2c_busy = 1'b0;
            d = cyc;
        end else begin
            good = 1'b0;
            while (cyc < s + TMO) tick();
            d = cyc;
        end
        model_outcome(good, f, gap);
        exp_next = d + gap + 1;
        tick();
        if (stray) begin
            dht_data = rnd_good(); dht_err = 1'b0; dht_done = 1'b1;
        end
        check_outputs(tag);
        tick();
        dht_done = 1'b0;
    endtask

    initial begin
        int s, cnt, dly, bh;
        logic [39:0] f;
        bit e;

        // Reset state
        RST = 1'b1;
        tick(); tick();
        check("rst_start", dht_start, 0);
        check_outputs("rst");
        RST = 1'b0;
        tick();
        enable = 1'b1;
        exp_next = cyc + 1;

        // Good frame, immediate commit
        attempt("good", 40'h3C00190055, 1'b0, 5, 0, 1'b0);
        // Deferred commit while I2C busy
        attempt("defer", mk(8'h01, 8'h02, 8'h03, 8'h04), 1'b0, 7, 30, 1'b0);
        // Bad checksum three times -> failed poll
        for (int i = 0; i < 3; i++) attempt("badcs", 40'h3C00190054, 1'b0, 3, 0, 1'b0);
        check("badcs_fault", fault, 1);
        // Checksum wrap-around
        attempt("wrap", 40'hFFFF010201, 1'b0, 4, 0, 1'b1);
        // Timeouts three times, then recovery
        for (int i = 0; i < 3; i++) attempt("tmo", 40'h0, 1'b0, 0, 0, 1'b0);
        attempt("tmo_recover", mk(8'h10, 8'h20, 8'h30, 8'h40), 1'b0, 9, 0, 1'b0);
        // dht_done coincident with the timeout cycle
        attempt("done_at_tmo", mk(8'h55, 8'h66, 8'h77, 8'h88), 1'b0, TMO, 0, 1'b0);
        // Protocol error with a correct checksum is a failure
        attempt("proto_err", mk(8'h01, 8'h01, 8'h01, 8'h01), 1'b1, 2, 0, 1'b0);
        attempt("after_err", mk(8'h21, 8'h00, 8'h19, 8'h00), 1'b0, 2, 0, 1'b1);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            f = rnd_good();
            if ($urandom_range(0, 1) == 1) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
            e   = ($urandom_range(0, 7) == 0);
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            bh  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            attempt("rand", f, e, dly, bh, 1'($urandom));
        end

        // Disable: the gap ends in IDLE and no further starts are issued
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < POLL + 30; i++) begin
            if (dht_start === 1'b1) cnt++;
            tick();
        end
        check("disabled_starts", cnt, 0);
        enable = 1'b1;
        exp_next = cyc + 1;
        attempt("reenable", mk(8'h0A, 8'h0B, 8'h0C, 8'h0D), 1'b0, 6, 0, 1'b0);

        // Reset mid-transaction, then a late dht_done
        wait_start(s);
        tick(); tick();
        RST = 1'b1; enable = 1'b0;
        tick();
        RST = 1'b0;
        m_reg = 40'h0; m_valid = 1'b0; m_fault = 1'b0; m_err = 0; m_retry = 0;
        dht_data = mk(8'h12, 8'h34, 8'h56, 8'h78); dht_err = 1'b0; dht_done = 1'b1;
        tick();
        dht_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (dht_start === 1'b1) cnt++;
            tick();
        end
        check("late_done_starts", cnt, 0);
        check_outputs("late_done");

        // Saturation of err_count over 256 failed polls
        enable = 1'b1;
        exp_next = cyc + 1;
        for (int p = 0; p < 256; p++) begin
            for (int r = 0; r <= int'(RMAX); r++) begin
                attempt("sat", {$urandom, 8'($urandom)}, 1'b1, int'($urandom_range(1, 3)), 0, 1'b0);
            end
        end
        check("sat_errcnt", err_count, 8'hFF);
        check("sat_fault", fault, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
